// File: rtl/instruction_loader_if.sv
// -----------------------------------------------------------------------------
// instruction_loader_if
//   Bundles the byte-stream input, the instruction-memory write port and the
//   load status signals of instruction_loader.
//   slave  : loader side (consumes i_*, drives o_*)
//   master : debug unit / memory side (drives i_*, observes o_*)
//   Signals: i_start, i_rx_data[7:0], i_rx_valid, i_mem_full,
//            o_instruction_write, o_instruction[WORD_SIZE_IN_BYTES*8-1:0],
//            o_busy, o_load_done, o_error, o_word_count,
//            o_timeout (only with INSTRUCTION_LOADER_TIMEOUT_EN defined)
// -----------------------------------------------------------------------------
interface instruction_loader_if #(
    parameter int WORD_SIZE_IN_BYTES = 4,
    parameter int MAX_WORDS          = 64
);
    localparam int WORD_W = WORD_SIZE_IN_BYTES * 8;
    localparam int CNT_W  = $clog2(MAX_WORDS + 1);

    logic              i_start;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              i_mem_full;
    logic              o_instruction_write;
    logic [WORD_W-1:0] o_instruction;
    logic              o_busy;
    logic              o_load_done;
    logic              o_error;
    logic [CNT_W-1:0]  o_word_count;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    logic              o_timeout;
`endif

    modport slave (
        input  i_start, i_rx_data, i_rx_valid, i_mem_full,
        output o_instruction_write, o_instruction, o_busy, o_load_done,
               o_error, o_word_count
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
        , output o_timeout
`endif
    );

    modport master (
        output i_start, i_rx_data, i_rx_valid, i_mem_full,
        input  o_instruction_write, o_instruction, o_busy, o_load_done,
               o_error, o_word_count
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
        , input o_timeout
`endif
    );
endinterface

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//   Loads a program into the instruction memory from a byte stream. Bytes are
//   assembled big-endian into words; each complete word gets a one-cycle write
//   strobe. The load ends on the HALT word (clean) or on memory full / capacity
//   reached (o_error set). o_load_done then lets the debug unit release the
//   pipeline.
//   Ports: i_clk, i_reset (async, active high), bus (instruction_loader_if.slave)
//   Optional: INSTRUCTION_LOADER_TIMEOUT_EN adds TIMEOUT_CYCLES and o_timeout;
//   a stalled partial word is then dropped after TIMEOUT_CYCLES idle cycles.
//   Requires WORD_SIZE_IN_BYTES >= 2.
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter int                            WORD_SIZE_IN_BYTES = 4,
    parameter logic [WORD_SIZE_IN_BYTES*8-1:0] HALT_WORD        = {WORD_SIZE_IN_BYTES{8'hFF}},
    parameter int                            MAX_WORDS          = 64
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    , parameter int                          TIMEOUT_CYCLES     = 1_000_000
`endif
) (
    input logic                  i_clk,
    input logic                  i_reset,
    instruction_loader_if.slave  bus
);
    localparam int WORD_W = WORD_SIZE_IN_BYTES * 8;
    localparam int CNT_W  = $clog2(MAX_WORDS + 1);
    localparam int BI_W   = $clog2(WORD_SIZE_IN_BYTES);
    localparam logic [BI_W-1:0]  LAST_IDX = BI_W'(WORD_SIZE_IN_BYTES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state;
    logic [BI_W-1:0]   byte_idx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] next_word;

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    // First byte ends up in the MSB after WORD_SIZE_IN_BYTES shifts.
    assign next_word = {shreg[WORD_W-9:0], bus.i_rx_data};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state                   <= IDLE;
            byte_idx                <= '0;
            shreg                   <= '0;
            bus.o_instruction_write <= 1'b0;
            bus.o_instruction       <= '0;
            bus.o_busy              <= 1'b0;
            bus.o_load_done         <= 1'b0;
            bus.o_error             <= 1'b0;
            bus.o_word_count        <= '0;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
            bus.o_timeout           <= 1'b0;
            to_cnt                  <= '0;
`endif
        end else begin
            bus.o_instruction_write <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        state            <= LOAD;
                        byte_idx         <= '0;
                        bus.o_word_count <= '0;
                        bus.o_error      <= 1'b0;
                        bus.o_busy       <= 1'b1;
                        bus.o_load_done  <= 1'b0;
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
                        bus.o_timeout    <= 1'b0;
                        to_cnt           <= '0;
`endif
                    end
                end

                LOAD: begin
                    if (bus.i_rx_valid) begin
                        shreg <= next_word;
                        if (byte_idx == LAST_IDX) begin
                            // Strobe and count are registered so both show up
                            // in the WRITE cycle, one cycle after the last byte.
                            byte_idx                <= '0;
                            bus.o_instruction       <= next_word;
                            bus.o_instruction_write <= 1'b1;
                            if (bus.o_word_count != MAX_CNT)
                                bus.o_word_count <= bus.o_word_count + 1'b1;
                            state <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
                    if (bus.i_rx_valid || byte_idx == '0) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // This idle cycle is the TIMEOUT_CYCLES-th: drop the partial word.
                        to_cnt        <= '0;
                        byte_idx      <= '0;
                        shreg         <= '0;
                        bus.o_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                WRITE: begin
                    // A byte arriving while the strobe is out starts the next word.
                    if (bus.i_rx_valid) begin
                        shreg    <= next_word;
                        byte_idx <= BI_W'(1);
                    end
                    if (bus.o_instruction == HALT_WORD) begin
                        state           <= DONE;
                        bus.o_busy      <= 1'b0;
                        bus.o_load_done <= 1'b1;
                    end else if (bus.i_mem_full || bus.o_word_count == MAX_CNT) begin
                        state           <= DONE;
                        bus.o_busy      <= 1'b0;
                        bus.o_load_done <= 1'b1;
                        bus.o_error     <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
    localparam int WB = 4;
    localparam int MW = 4;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   wr_cnt = 0;
    logic [31:0] wr_log[$];

    instruction_loader_if #(.WORD_SIZE_IN_BYTES(WB), .MAX_WORDS(MW)) bus ();

    instruction_loader #(
        .WORD_SIZE_IN_BYTES(WB),
        .HALT_WORD(32'hFFFFFFFF),
        .MAX_WORDS(MW)
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .bus(bus)
    );

    always #5 i_clk = ~i_clk;

    // Write-strobe monitor, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (bus.o_instruction_write === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            wr_log.push_back(bus.o_instruction);
        end
    end

    // All stimulus tasks are entered at a negedge and leave at the next negedge.
    task automatic cyc(input logic v, input logic [7:0] d);
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        @(negedge i_clk);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        cyc(1'b1, w[31:24]);
        cyc(1'b1, w[23:16]);
        cyc(1'b1, w[15:8]);
        cyc(1'b1, w[7:0]);
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
    endtask

    task automatic hard_reset();
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        wr_cnt = 0;
        wr_log.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({bus.o_instruction_write, bus.o_busy, bus.o_load_done, bus.o_error} !== 4'b0 ||
            bus.o_instruction !== 32'h0 || bus.o_word_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: wr=%b busy=%b done=%b err=%b instr=%h cnt=%0d, expected all 0",
                     bus.o_instruction_write, bus.o_busy, bus.o_load_done, bus.o_error,
                     bus.o_instruction, bus.o_word_count);
        end
        i_reset = 1'b0;
        cyc(1'b1, 8'h55);  // bytes ignored in IDLE
        checks++;
        if (bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_rx: busy=%b expected 0", bus.o_busy);
        end
        wr_cnt = 0;
        wr_log.delete();
    endtask

    task automatic test_single_word();
        hard_reset();
        pulse_start();
        checks++;
        if (bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL start_busy: busy=%b expected 1", bus.o_busy);
        end
        cyc(1'b1, 8'h20);
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h00);
        checks++;
        if (bus.o_instruction_write !== 1'b0) begin
            failures++;
            $display("FAIL early_strobe: wr=%b expected 0", bus.o_instruction_write);
        end
        cyc(1'b1, 8'h05);
        checks++;
        if (bus.o_instruction_write !== 1'b1 || bus.o_instruction !== 32'h20010005 ||
            bus.o_word_count !== 3'd1 || bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_word: wr=%b instr=%h cnt=%0d busy=%b expected 1 20010005 1 1",
                     bus.o_instruction_write, bus.o_instruction, bus.o_word_count, bus.o_busy);
        end
        cyc(1'b0, 8'h00);
        checks++;
        if (bus.o_instruction_write !== 1'b0 || bus.o_instruction !== 32'h20010005 || wr_cnt !== 1) begin
            failures++;
            $display("FAIL single_word_after: wr=%b instr=%h writes=%0d expected 0 20010005 1",
                     bus.o_instruction_write, bus.o_instruction, wr_cnt);
        end
    endtask

    task automatic test_halt();
        hard_reset();
        pulse_start();
        send_word(32'h00000001);
        send_word(32'h00000002);
        send_word(32'h00000003);
        send_word(32'hFFFFFFFF);
        cyc(1'b0, 8'h00);
        checks++;
        if (bus.o_load_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_error !== 1'b0 ||
            bus.o_word_count !== 3'd4) begin
            failures++;
            $display("FAIL halt_status: done=%b busy=%b err=%b cnt=%0d expected 1 0 0 4",
                     bus.o_load_done, bus.o_busy, bus.o_error, bus.o_word_count);
        end
        checks++;
        if (wr_cnt !== 4 || wr_log.size() != 4) begin
            failures++;
            $display("FAIL halt_writes: writes=%0d expected 4", wr_cnt);
        end else if (wr_log[3] !== 32'hFFFFFFFF || wr_log[0] !== 32'h00000001) begin
            failures++;
            $display("FAIL halt_words: first=%h last=%h expected 00000001 ffffffff", wr_log[0], wr_log[3]);
        end
        cyc(1'b1, 8'h12);  // ignored in DONE
        cyc(1'b0, 8'h00);
        checks++;
        if (wr_cnt !== 4 || bus.o_load_done !== 1'b1) begin
            failures++;
            $display("FAIL done_ignores_rx: writes=%0d done=%b expected 4 1", wr_cnt, bus.o_load_done);
        end
    endtask

    task automatic test_max_words();
        hard_reset();
        pulse_start();
        send_word(32'h0A0B0C0D);
        send_word(32'h1A1B1C1D);
        send_word(32'h2A2B2C2D);
        send_word(32'h3A3B3C3D);
        checks++;
        if (bus.o_instruction_write !== 1'b1 || bus.o_word_count !== 3'd4 || bus.o_error !== 1'b0) begin
            failures++;
            $display("FAIL max_fourth_write: wr=%b cnt=%0d err=%b expected 1 4 0",
                     bus.o_instruction_write, bus.o_word_count, bus.o_error);
        end
        cyc(1'b0, 8'h00);
        checks++;
        if (bus.o_error !== 1'b1 || bus.o_load_done !== 1'b1 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL max_error: err=%b done=%b busy=%b expected 1 1 0",
                     bus.o_error, bus.o_load_done, bus.o_busy);
        end
        send_word(32'h4A4B4C4D);
        cyc(1'b0, 8'h00);
        checks++;
        if (wr_cnt !== 4 || bus.o_word_count !== 3'd4) begin
            failures++;
            $display("FAIL max_no_more: writes=%0d cnt=%0d expected 4 4", wr_cnt, bus.o_word_count);
        end
        pulse_start();  // new load from DONE clears sticky state
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_error !== 1'b0 || bus.o_word_count !== 3'd0 ||
            bus.o_load_done !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear: busy=%b err=%b cnt=%0d done=%b expected 1 0 0 0",
                     bus.o_busy, bus.o_error, bus.o_word_count, bus.o_load_done);
        end
    endtask

    task automatic test_mem_full();
        hard_reset();
        pulse_start();
        bus.i_mem_full = 1'b1;
        send_word(32'h01234567);
        cyc(1'b0, 8'h00);
        bus.i_mem_full = 1'b0;
        checks++;
        if (bus.o_error !== 1'b1 || bus.o_load_done !== 1'b1 || bus.o_word_count !== 3'd1 || wr_cnt !== 1) begin
            failures++;
            $display("FAIL mem_full: err=%b done=%b cnt=%0d writes=%0d expected 1 1 1 1",
                     bus.o_error, bus.o_load_done, bus.o_word_count, wr_cnt);
        end
    endtask

    task automatic test_reset_mid_word();
        hard_reset();
        pulse_start();
        cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'hBB);
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if (bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b expected 0 without a clock edge", bus.o_busy);
        end
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        pulse_start();
        send_word(32'h11223344);
        cyc(1'b0, 8'h00);
        checks++;
        if (wr_cnt !== 1 || wr_log.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_writes: writes=%0d expected 1", wr_cnt);
        end else if (wr_log[0] !== 32'h11223344) begin
            failures++;
            $display("FAIL reset_mid_word: word=%h expected 11223344", wr_log[0]);
        end
    endtask

    task automatic test_back_to_back();
        hard_reset();
        pulse_start();
        send_word(32'h01020304);
        checks++;
        if (bus.o_instruction_write !== 1'b1) begin
            failures++;
            $display("FAIL b2b_strobe: wr=%b expected 1", bus.o_instruction_write);
        end
        send_word(32'h05060708);  // first byte lands in the WRITE cycle
        send_word(32'hFFFFFFFF);
        cyc(1'b0, 8'h00);
        checks++;
        if (wr_cnt !== 3 || wr_log.size() != 3) begin
            failures++;
            $display("FAIL b2b_writes: writes=%0d expected 3", wr_cnt);
        end else if (wr_log[0] !== 32'h01020304 || wr_log[1] !== 32'h05060708 || wr_log[2] !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL b2b_words: %h %h %h expected 01020304 05060708 ffffffff",
                     wr_log[0], wr_log[1], wr_log[2]);
        end
        checks++;
        if (bus.o_load_done !== 1'b1 || bus.o_word_count !== 3'd3 || bus.o_error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_status: done=%b cnt=%0d err=%b expected 1 3 0",
                     bus.o_load_done, bus.o_word_count, bus.o_error);
        end
    endtask

    task automatic test_start_ignored_in_load();
        hard_reset();
        pulse_start();
        send_word(32'h00000011);
        cyc(1'b0, 8'h00);
        pulse_start();  // ignored in LOAD: count must survive
        checks++;
        if (bus.o_word_count !== 3'd1 || bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL start_in_load: cnt=%0d busy=%b expected 1 1", bus.o_word_count, bus.o_busy);
        end
    endtask

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        hard_reset();
        pulse_start();
        cyc(1'b1, 8'h77);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00);
        checks++;
        if (bus.o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: timeout=%b expected 0 after 15 idle cycles", bus.o_timeout);
        end
        cyc(1'b0, 8'h00);
        checks++;
        if (bus.o_timeout !== 1'b1 || bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set: timeout=%b busy=%b expected 1 1", bus.o_timeout, bus.o_busy);
        end
        send_word(32'hAABBCCDD);
        cyc(1'b0, 8'h00);
        checks++;
        if (wr_cnt !== 1 || wr_log.size() != 1) begin
            failures++;
            $display("FAIL timeout_writes: writes=%0d expected 1", wr_cnt);
        end else if (wr_log[0] !== 32'hAABBCCDD) begin
            failures++;
            $display("FAIL timeout_word: word=%h expected aabbccdd", wr_log[0]);
        end
    endtask
`endif

    initial begin
        bus.i_start    = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_mem_full = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_single_word();
        test_halt();
        test_max_words();
        test_mem_full();
        test_reset_mid_word();
        test_back_to_back();
        test_start_ignored_in_load();
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Sequences program load into the IF-stage instruction memory from a byte stream (debug UART RX).
- Assembles bytes into instruction words and issues one-cycle write strobes to the memory.
- Detects the HALT word and the memory-full condition, then reports load completion so the debug unit can release the pipeline.
- Sits between the UART RX / debug unit and the instruction memory write port.

Parameters:
- WORD_SIZE_IN_BYTES, 4, bytes per instruction word.
- HALT_WORD, 32'hFFFFFFFF, word value that terminates the load. Width is WORD_SIZE_IN_BYTES*8.
- MAX_WORDS, 64, instruction memory capacity in words. Word counter width is $clog2(MAX_WORDS+1).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse that arms a new load. Honoured only in IDLE or DONE.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- i_mem_full  in  1  instruction memory full flag.
- o_instruction_write  out  1  one-cycle write strobe to the instruction memory.
- o_instruction  out  WORD_SIZE_IN_BYTES*8  assembled word. Held stable while the strobe is high and until the next word completes.
- o_busy  out  1  high in LOAD and WRITE.
- o_load_done  out  1  high in DONE.
- o_error  out  1  sticky overflow flag; cleared by reset or i_start.
- o_word_count  out  $clog2(MAX_WORDS+1)  words written in the current load, HALT included.

Behaviour:
- Reset (async): state=IDLE, byte index=0, word shift register=0, all outputs 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE -> LOAD on i_start. Entry clears byte index, o_word_count and o_error. i_rx_valid is ignored in IDLE and DONE.
- LOAD, byte assembly:
  - Each i_rx_valid shifts i_rx_data into the word register, big-endian: the first byte becomes the MSB.
  - Byte index increments on each valid byte.
  - When the WORD_SIZE_IN_BYTES-th byte arrives, the full word is latched onto o_instruction, byte index returns to 0, and the state moves to WRITE on the next edge.
- WRITE (exactly one cycle):
  - o_instruction_write=1 and o_word_count increments, both in this cycle.
  - If the word equals HALT_WORD -> DONE.
  - Else, if i_mem_full=1 or the incremented count equals MAX_WORDS -> set o_error, go to DONE.
  - Else -> LOAD.
  - An i_rx_valid arriving during WRITE is captured as byte 0 of the next word; no byte is dropped.
- Latency: last byte strobe at edge N -> o_instruction_write high during cycle N+1. Minimum spacing between strobes is WORD_SIZE_IN_BYTES cycles.
- DONE: o_load_done=1. Stays until i_start (-> LOAD, new load) or reset.
- i_start while in LOAD or WRITE is ignored.
- Reset mid-word discards the partial word. No write strobe is issued during or after reset.
- o_word_count saturates at MAX_WORDS; it never wraps.

Optional Feature:
- INSTRUCTION_LOADER_TIMEOUT_EN:
  - When defined, adds parameter TIMEOUT_CYCLES (default 1_000_000) and output o_timeout (1 bit, sticky, cleared by reset or i_start).
  - In LOAD with byte index != 0, a counter increments each cycle without i_rx_valid and clears on i_rx_valid.
  - When the counter reaches TIMEOUT_CYCLES, the partial word is discarded, byte index resets to 0, o_timeout is set, and the state stays in LOAD.
- When not defined: no counter, no o_timeout port, and a partial word waits indefinitely.

Test Plan:
- Reset, then i_start, then bytes 8'h20,8'h01,8'h00,8'h05 -> single o_instruction_write pulse with o_instruction=32'h20010005 one cycle after the 4th byte; o_word_count=1; o_busy=1.
- Load 3 words, then FF,FF,FF,FF -> 4 write pulses total (HALT written); o_load_done=1; o_word_count=4; o_error=0.
- MAX_WORDS=4, 4 non-HALT words -> 4th write pulse, then o_error=1 and o_load_done=1; further bytes produce no write.
- 2 bytes, then async reset pulse, then i_start and 4 bytes 11,22,33,44 -> exactly one write with 32'h11223344; old bytes absent.
- i_rx_valid on the cycle of a write strobe -> that byte becomes the MSB of the next word; back-to-back bytes every cycle produce correct consecutive words.
- With INSTRUCTION_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: 1 byte, 16 idle cycles, then 4 bytes AA,BB,CC,DD -> o_timeout=1 and the written word is 32'hAABBCCDD.
